// File: rtl/dm_bus_slave_pkg.sv
// Shared data-memory definitions: bus widths, responder state encodings and the byte-lane merge helper.
package dm_bus_slave_pkg;

  localparam int DM_WIDTH      = 32;
  localparam int DMIn_BE_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dm_state_e;

  function automatic logic [DM_WIDTH-1:0] be_merge(
    input logic [DM_WIDTH-1:0]      old_word,
    input logic [DM_WIDTH-1:0]      new_word,
    input logic [DMIn_BE_WIDTH-1:0] be
  );
    logic [DM_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < DMIn_BE_WIDTH; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_sram_array.sv
// Word array with synchronous byte-lane writes and asynchronous reads; contents are never reset.
module dm_sram_array
  import dm_bus_slave_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [DMIn_BE_WIDTH-1:0] BE,
  input  logic [IDX_W-1:0]         index,
  input  logic [DM_WIDTH-1:0]      din,
  output logic [DM_WIDTH-1:0]      dout
);

  logic [DM_WIDTH-1:0] mem_q [DEPTH_WORDS];

  // byte-lane write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[index] <= be_merge(mem_q[index], din, BE);
    end
  end

  assign dout = mem_q[index];

endmodule

// File: rtl/dm_bus_slave.sv
// Data-memory responder with req/ready handshake and WAIT_CYCLES wait states.
// Optional macro DM_RANGE_ERR_EN: flag out-of-range accesses via err instead of wrapping the index.
module dm_bus_slave
  import dm_bus_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     wr,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [DMIn_BE_WIDTH-1:0] BE,
  input  logic [DM_WIDTH-1:0]      din,
  output logic                     ready,
  output logic [DM_WIDTH-1:0]      dout,
  output logic                     err
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? (($clog2(WAIT_CYCLES + 1) > 0) ? $clog2(WAIT_CYCLES + 1) : 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};

`ifndef DM_RANGE_ERR_EN
  generate
    if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_depth_chk
      $error("dm_bus_slave: DEPTH_WORDS must be a power of two when the index wraps");
    end
  endgenerate
`endif

  dm_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic                    oor_q, oor_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DMIn_BE_WIDTH-1:0] be_q, be_d;
  logic [DM_WIDTH-1:0]     din_q, din_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [DM_WIDTH-1:0]     dout_q, dout_d;

  logic [IW-1:0]           in_idx_s;
  logic                    in_oor_s;
  logic [IDX_W-1:0]        arr_idx_s;
  logic [DM_WIDTH-1:0]     arr_dout_s;
  logic                    we_s;
  logic                    arr_we_s;
  logic                    unused_s;

  assign in_idx_s = addr[ADDR_WIDTH-1:2];

`ifdef DM_RANGE_ERR_EN
  assign in_oor_s = ({{(64-IW){1'b0}}, in_idx_s} >= 64'(DEPTH_WORDS));
`else
  assign in_oor_s = 1'b0;
`endif

  // array address: the incoming request while idle, the latched one afterwards
  always_comb begin
    arr_idx_s = idx_q[IDX_W-1:0];
    if (state_q == IDLE) begin
      arr_idx_s = in_idx_s[IDX_W-1:0];
    end else begin
      arr_idx_s = idx_q[IDX_W-1:0];
    end
  end

  // a write landing on the same edge reset rises is dropped
  assign arr_we_s = we_s & ~rst;
  assign unused_s = ^{addr[1:0], idx_q, in_idx_s};

  dm_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we_s),
    .BE   (be_q),
    .index(arr_idx_s),
    .din  (din_q),
    .dout (arr_dout_s)
  );

  // next-state, request latching and registered response values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    oor_d   = oor_q;
    idx_d   = idx_q;
    be_d    = be_q;
    din_d   = din_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    dout_d  = dout_q;
    we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d  = wr;
          oor_d = in_oor_s;
          idx_d = in_idx_s;
          be_d  = BE;
          din_d = din;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            ready_d = 1'b1;
            err_d   = in_oor_s;
            if (wr) begin
              dout_d = dout_q;
            end else if (in_oor_s) begin
              dout_d = {DM_WIDTH{1'b0}};
            end else begin
              dout_d = arr_dout_s;
            end
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = oor_q;
          if (wr_q) begin
            dout_d = dout_q;
          end else if (oor_q) begin
            dout_d = {DM_WIDTH{1'b0}};
          end else begin
            dout_d = arr_dout_s;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        we_s    = wr_q & ~oor_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      idx_q   <= {IW{1'b0}};
      be_q    <= {DMIn_BE_WIDTH{1'b0}};
      din_q   <= {DM_WIDTH{1'b0}};
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= {DM_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      oor_q   <= oor_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      din_q   <= din_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  assign ready = ready_q;
  assign err   = err_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_dm_bus_slave.sv
// Directed bench for dm_bus_slave: three instances with WAIT_CYCLES of 0, 1 and 3.
module tb_dm_bus_slave;

  logic        clk = 1'b0;
  logic        rst, wr;
  logic [31:0] addr, din;
  logic [3:0]  be;
  logic        req0, req1, req3;
  logic        ready0, ready1, ready3;
  logic [31:0] dout0, dout1, dout3;
  logic        err0, err1, err3;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dm_bus_slave #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .wr(wr), .addr(addr), .BE(be), .din(din),
    .ready(ready0), .dout(dout0), .err(err0));
  dm_bus_slave #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .wr(wr), .addr(addr), .BE(be), .din(din),
    .ready(ready1), .dout(dout1), .err(err1));
  dm_bus_slave #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .wr(wr), .addr(addr), .BE(be), .din(din),
    .ready(ready3), .dout(dout3), .err(err3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return ready0;
      3:       return ready3;
      default: return ready1;
    endcase
  endfunction

  task automatic set_req(input int sel, input logic v);
    case (sel)
      0:       req0 = v;
      3:       req3 = v;
      default: req1 = v;
    endcase
  endtask

  task automatic txn(input int sel, input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    wr = w; addr = a; be = b; din = d;
    set_req(sel, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rdy(sel) && lat < 20);
    rd = (sel == 0) ? dout0 : (sel == 3) ? dout3 : dout1;
    e  = (sel == 0) ? err0  : (sel == 3) ? err3  : err1;
    set_req(sel, 1'b0);
    @(negedge clk);
    check("single_pulse", {31'b0, rdy(sel)}, 32'h0);
  endtask

  // req held high for four reads: first response after wc+1, then every wc+2 cycles
  task automatic burst(input int sel, input int wc);
    int cyc;
    int np;
    int pc[4];
    int extra;
    cyc = 0; np = 0; extra = 0;
    @(negedge clk);
    wr = 1'b0; addr = 32'h10; be = 4'h0; din = 32'h0;
    set_req(sel, 1'b1);
    while (np < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rdy(sel)) begin
        pc[np] = cyc;
        np++;
      end
    end
    set_req(sel, 1'b0);
    check($sformatf("burst%0d_count", wc), 32'(np), 32'd4);
    check($sformatf("burst%0d_first", wc), 32'(pc[0]), 32'(wc + 1));
    for (int i = 1; i < 4; i++) begin
      check($sformatf("burst%0d_gap%0d", wc, i), 32'(pc[i] - pc[i-1]), 32'(wc + 2));
    end
    repeat (6) begin
      @(negedge clk);
      extra += int'(rdy(sel));
    end
    check($sformatf("burst%0d_after", wc), 32'(extra), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          pulses;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; req3 = 1'b0;
    wr = 1'b0; addr = 32'h0; din = 32'h0; be = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, ready1}, 32'h0);
    check("rst_dout",  dout1, 32'h0);
    check("rst_err",   {31'b0, err1}, 32'h0);
    rst = 1'b0;

    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      pulses += int'(ready0) + int'(ready1) + int'(ready3);
    end
    check("idle_no_ready", 32'(pulses), 32'd0);

    txn(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, e, lat);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_err", {31'b0, e}, 32'h0);
    txn(1, 1'b0, 32'h10, 4'h0, 32'h0, rd, e, lat);
    check("rd_lat",  32'(lat), 32'd2);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_err",  {31'b0, e}, 32'h0);

    #2 rst = 1'b1;
    #1;
    check("async_rst_dout",  dout1, 32'h0);
    check("async_rst_ready", {31'b0, ready1}, 32'h0);
    check("async_rst_err",   {31'b0, err1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    txn(1, 1'b0, 32'h10, 4'h0, 32'h0, rd, e, lat);
    check("rd_after_rst", rd, 32'hDEADBEEF);

    // req dropped while waiting still completes
    @(negedge clk);
    wr = 1'b0; addr = 32'h10; req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
    check("drop_req_ready", {31'b0, ready1}, 32'h1);
    check("drop_req_data",  dout1, 32'hDEADBEEF);
    @(negedge clk);

    txn(1, 1'b1, 32'h14, 4'hF, 32'hAAAAAAAA, rd, e, lat);
    txn(1, 1'b1, 32'h14, 4'b0101, 32'h11223344, rd, e, lat);
    txn(1, 1'b0, 32'h14, 4'h0, 32'h0, rd, e, lat);
    check("lane_merge", rd, 32'hAA22AA44);
    txn(1, 1'b1, 32'h14, 4'h0, 32'hFFFFFFFF, rd, e, lat);
    check("be0_lat",       32'(lat), 32'd2);
    check("wr_dout_holds", rd, 32'hAA22AA44);
    txn(1, 1'b0, 32'h14, 4'h0, 32'h0, rd, e, lat);
    check("be0_unchanged", rd, 32'hAA22AA44);

    txn(1, 1'b1, 32'h0, 4'hF, 32'h01020304, rd, e, lat);
    txn(1, 1'b1, 32'h1000, 4'hF, 32'h5555AAAA, rd, e, lat);
`ifdef DM_RANGE_ERR_EN
    check("oor_wr_err", {31'b0, e}, 32'h1);
    txn(1, 1'b0, 32'h0, 4'h0, 32'h0, rd, e, lat);
    check("oor_word0_kept", rd, 32'h01020304);
    txn(1, 1'b0, 32'h1000, 4'h0, 32'h0, rd, e, lat);
    check("oor_rd_data", rd, 32'h0);
    check("oor_rd_err",  {31'b0, e}, 32'h1);
`else
    check("wrap_wr_err", {31'b0, e}, 32'h0);
    txn(1, 1'b0, 32'h0, 4'h0, 32'h0, rd, e, lat);
    check("wrap_word0", rd, 32'h5555AAAA);
    txn(1, 1'b0, 32'h1000, 4'h0, 32'h0, rd, e, lat);
    check("wrap_rd_data", rd, 32'h5555AAAA);
    check("wrap_rd_err",  {31'b0, e}, 32'h0);
`endif

    burst(0, 0);
    burst(3, 3);

    txn(3, 1'b1, 32'h20, 4'hF, 32'h12345678, rd, e, lat);
    check("wc3_wr_lat", 32'(lat), 32'd4);
    @(negedge clk);
    wr = 1'b1; addr = 32'h20; din = 32'hCAFEF00D; be = 4'hF; req3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    req3 = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      pulses += int'(ready3);
    end
    check("midop_rst_no_ready", 32'(pulses), 32'd0);
    rst = 1'b0;
    txn(3, 1'b0, 32'h20, 4'h0, 32'h0, rd, e, lat);
    check("midop_old_value", rd, 32'h12345678);
    check("wc3_rd_lat",      32'(lat), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dm_bus_slave.md
Name: dm_bus_slave

Overview:
- Data-memory responder at the far end of the core's M-stage memory port (addr/BE/din/wr out, dout in).
- Accepts one word-wide request per transaction with a req/ready handshake.
- Applies byte-lane writes, returns full-word read data, and inserts a configurable number of wait states.
- Lets the pipeline run against a memory with non-zero latency; the core stalls until ready.

Parameters:
ADDR_WIDTH, 32, byte-address width of addr
DEPTH_WORDS, 1024, number of 32-bit words in the array
WAIT_CYCLES, 1, idle cycles between request accept and response (0 allowed)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  1  request valid; requester holds it and all request fields stable until ready
wr  input  1  1 = write, 0 = read
addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored
BE  input  4  byte-lane enables for writes (bit i = byte lane i = din[8i+7:8i])
din  input  32  write data, already lane-aligned by the requester
ready  output  1  one-cycle response strobe
dout  output  32  read data, valid when ready=1 on a read
err  output  1  address-out-of-range flag, valid with ready

Behaviour:
- Reset (async, rst=1): state=IDLE, ready=0, dout=0, err=0, wait counter=0. Array contents are not cleared.
- Word index = addr[ADDR_WIDTH-1:2]. Range check: index < DEPTH_WORDS.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req=1: latch wr, index, BE, din.
  - If WAIT_CYCLES=0, go to RESP; otherwise load counter=WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - Decrement counter each cycle.
  - When counter=0, go to RESP.
- Transition into RESP (registered outputs):
  - ready<=1 and err<=out_of_range.
  - Read in range: dout<=array[index].
  - Read out of range: dout<=0.
  - Write: dout holds its previous value.
- RESP:
  - ready=1 for exactly one cycle.
  - Write in range: each lane with BE[i]=1 is updated on the clock edge ending RESP. BE=0 is a legal no-op write with a normal response.
  - Out-of-range write: no lane written.
  - Next state is always IDLE; ready<=0 and err<=0.
- Latency: ready asserts WAIT_CYCLES+1 cycles after the cycle req is first sampled in IDLE.
  - Minimum spacing between accepted requests is WAIT_CYCLES+2 cycles.
  - req seen during WAIT or RESP belongs to the current transaction and is never accepted twice. A new request is sampled only in IDLE.
- Dropping req during WAIT does not abort the transaction; it still completes and pulses ready.
- Read-after-write: a read accepted after a write's RESP returns the updated word, because the write commits before the next IDLE accept.
- Reset mid-operation: FSM returns to IDLE immediately and ready/err/dout go to 0.
  - A pending write that has not reached the end of RESP is discarded.
  - A write completing on the same edge that rst rises is discarded.
- Counter width: $clog2(WAIT_CYCLES+1), minimum 1.

Optional Feature:
- Macro DM_RANGE_ERR_EN.
- Defined: out-of-range behaviour as above (err=1, no write, read dout=0).
- Undefined:
  - Index wraps modulo DEPTH_WORDS, which must be a power of two; an elaboration check fails otherwise.
  - err is tied to 0.
  - All accesses behave as in-range.

Decomposition:
- Shared package/header (with the existing DM definitions):
  - DM_WIDTH (32) and DMIn_BE_WIDTH (4).
  - dm_bus_slave state encodings: IDLE=2'b00, WAIT=2'b01, RESP=2'b10.
- Sub-module dm_sram_array:
  - Synchronous byte-lane-write, asynchronous-read word array.
  - Ports clk, we, BE, index, din, dout; parameter DEPTH_WORDS.
- The FSM, counter and range check stay in dm_bus_slave.

Test Plan:
- Reset/idle: assert rst mid-simulation -> ready=0, dout=0, err=0 immediately (async). Holding req=0 -> ready never pulses.
- Word write then read, WAIT_CYCLES=1: write addr=0x10, BE=4'hF, din=0xDEADBEEF, then read addr=0x10 -> ready 2 cycles after each accept, dout=0xDEADBEEF, err=0.
- Byte lanes: write 0x11223344 with BE=4'b0101 over a word holding 0xAAAAAAAA -> read returns 0xAA22AA44. Write with BE=0 -> word unchanged, ready still pulses once.
- WAIT_CYCLES=0 and WAIT_CYCLES=3 builds: hold req continuously for 4 reads -> ready spacing 2 and 5 cycles respectively, exactly one pulse per transaction.
- Out of range (DEPTH_WORDS=1024), write to addr=0x1000:
  - DM_RANGE_ERR_EN defined -> err=1 with ready; word 0 unchanged; read of 0x1000 gives dout=0, err=1.
  - DM_RANGE_ERR_EN undefined -> the same write lands in word 0 and err stays 0.
- Reset mid-op: WAIT_CYCLES=3 write to 0x20, assert rst during WAIT, release, then read 0x20 -> old value returned, no spurious ready during reset.
